// File: rtl/modn_down_counter_pkg.sv
// Shared types and helpers for the loadable mod-N down counter.
package counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int unsigned clamp_mod(
    input int unsigned value,
    input int unsigned mod
  );
    return (value >= mod) ? mod - 1 : value;
  endfunction

endpackage

// File: rtl/modn_down_counter_if.sv
// Control/status bundle between a controller and the mod-N down counter.
interface modn_down_counter_if #(
  parameter int WIDTH = 3
);

  logic             start;
  logic [WIDTH-1:0] load_value;
  logic             enable;
  logic             abort;
  logic [WIDTH-1:0] value;
  logic             busy;
  logic             borrow;
  logic             done;

  modport master (
    output start, load_value, enable, abort,
    input  value, busy, borrow, done
  );

  modport slave (
    input  start, load_value, enable, abort,
    output value, busy, borrow, done
  );

endinterface

// File: rtl/modn_down_counter.sv
// Loadable mod-N down counter/timer with borrow pulse and done level.
// Define AUTO_RELOAD_EN to reload from the start value instead of stopping.
module modn_down_counter
  import counter_pkg::*;
#(
  parameter int unsigned MOD   = 7,
  parameter int          WIDTH = $clog2(MOD)
) (
  input logic clock,
  input logic reset,
  modn_down_counter_if.slave bus
);

  state_t           state_q;
  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] reload_q;
  logic             busy_q;
  logic             borrow_q;
  logic             done_q;
  logic [WIDTH-1:0] load_d;

  assign load_d = WIDTH'(clamp_mod(32'(bus.load_value), MOD));

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= IDLE;
      value_q  <= '0;
      reload_q <= '0;
      busy_q   <= 1'b0;
      borrow_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      borrow_q <= 1'b0;
      unique case (state_q)
        IDLE, DONE: begin
          if (bus.abort) begin
            state_q <= IDLE;
            value_q <= '0;
            done_q  <= 1'b0;
          end else if (bus.start) begin
            value_q  <= load_d;
            reload_q <= load_d;
            // A zero start value finishes on the load edge itself.
            if (load_d != '0) begin
              state_q <= RUN;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end else begin
              state_q  <= DONE;
              borrow_q <= 1'b1;
              done_q   <= 1'b1;
            end
          end
        end
        RUN: begin
          if (bus.abort) begin
            state_q <= IDLE;
            value_q <= '0;
            busy_q  <= 1'b0;
          end else if (bus.enable) begin
            if (value_q > WIDTH'(1)) begin
              value_q <= value_q - WIDTH'(1);
            end else if (value_q == WIDTH'(1)) begin
              value_q  <= '0;
              borrow_q <= 1'b1;
`ifndef AUTO_RELOAD_EN
              state_q  <= DONE;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
`endif
            end else begin
              value_q <= reload_q;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          value_q <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.value  = value_q;
  assign bus.busy   = busy_q;
  assign bus.borrow = borrow_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_modn_down_counter.sv
// Directed self-checking bench for modn_down_counter (MOD=7).
// Build with AUTO_RELOAD_EN defined to exercise the reload sequence.
module tb_modn_down_counter;

  localparam int MOD   = 7;
  localparam int WIDTH = 3;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  modn_down_counter_if #(.WIDTH(WIDTH)) bus ();

  modn_down_counter #(
    .MOD  (MOD),
    .WIDTH(WIDTH)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_all(input string tag, input int v, input int b,
                         input int bo, input int d);
    chk({tag, ".value"},  int'(bus.value),  v);
    chk({tag, ".busy"},   int'(bus.busy),   b);
    chk({tag, ".borrow"}, int'(bus.borrow), bo);
    chk({tag, ".done"},   int'(bus.done),   d);
  endtask

  task automatic do_start(input int lv);
    bus.start      = 1'b1;
    bus.load_value = WIDTH'(lv);
    step();
    bus.start      = 1'b0;
  endtask

  initial begin
    int exp3 [6] = '{3, 2, 2, 1, 1, 0};

    bus.start      = 1'b1;
    bus.load_value = 3'd5;
    bus.enable     = 1'b0;
    bus.abort      = 1'b0;

    // 1: reset overrides start
    step();
    step();
    chk_all("rst", 0, 0, 0, 0);
    bus.start = 1'b0;
    reset     = 1'b1;
    step();
    chk_all("idle", 0, 0, 0, 0);

`ifndef AUTO_RELOAD_EN
    // 2: load 5 and count down to done
    bus.enable = 1'b1;
    do_start(5);
    chk_all("t2.load", 5, 1, 0, 0);
    for (int i = 4; i >= 1; i--) begin
      step();
      chk_all($sformatf("t2.v%0d", i), i, 1, 0, 0);
    end
    step();
    chk_all("t2.zero", 0, 0, 1, 1);
    step();
    chk_all("t2.hold", 0, 0, 0, 1);

    // 3: enable toggling, 3 enabled edges in 6
    do_start(3);
    for (int i = 0; i < 6; i++) begin
      bus.enable = (i % 2) == 1;
      step();
      chk($sformatf("t3.e%0d", i), int'(bus.value), exp3[i]);
      chk($sformatf("t3.bo%0d", i), int'(bus.borrow), (i == 5) ? 1 : 0);
    end
    chk("t3.done", int'(bus.done), 1);

    // 4: out-of-range load clamps to MOD-1; start during RUN ignored
    bus.enable = 1'b0;
    do_start(7);
    chk_all("t4.clamp", 6, 1, 0, 0);
    bus.start      = 1'b1;
    bus.load_value = 3'd2;
    step();
    bus.start      = 1'b0;
    chk_all("t4.ign", 6, 1, 0, 0);
    bus.enable = 1'b1;
    for (int i = 5; i >= 1; i--) begin
      step();
      chk($sformatf("t4.v%0d", i), int'(bus.value), i);
    end
    step();
    chk_all("t4.zero", 0, 0, 1, 1);

    // 5: abort + start at value 2, abort wins
    do_start(4);
    chk("t5.load", int'(bus.value), 4);
    step();
    step();
    chk("t5.two", int'(bus.value), 2);
    bus.abort = 1'b1;
    bus.start = 1'b1;
    step();
    bus.abort = 1'b0;
    bus.start = 1'b0;
    chk_all("t5.abort", 0, 0, 0, 0);
    step();
    chk_all("t5.idle", 0, 0, 0, 0);

    // zero load finishes at once; abort in DONE clears done
    do_start(0);
    chk_all("z.load", 0, 0, 1, 1);
    step();
    chk_all("z.hold", 0, 0, 0, 1);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk_all("z.abort", 0, 0, 0, 0);
`else
    // 6: auto reload 2,1,0,2,1,0 then reset mid-run
    bus.enable = 1'b1;
    do_start(2);
    chk_all("t6.load", 2, 1, 0, 0);
    begin
      int ev [5] = '{1, 0, 2, 1, 0};
      int eb [5] = '{0, 1, 0, 0, 1};
      for (int i = 0; i < 5; i++) begin
        step();
        chk_all($sformatf("t6.s%0d", i), ev[i], 1, eb[i], 0);
      end
    end
    step();
    chk_all("t6.rel", 2, 1, 0, 0);
    reset = 1'b0;
    step();
    chk_all("t6.rst", 0, 0, 0, 0);
    reset = 1'b1;
    step();
    chk_all("t6.idle", 0, 0, 0, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
